// File: rtl/reg_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and instruction field positions for the
// register-file access sequencer.
package reg_ctrl_pkg;

  localparam int INSTR_W = 8;
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 5;
  localparam int R_LSB   = 2;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDA  = 3'd1;
  localparam logic [2:0] OP_STA  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_READ,
    ST_EXEC,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_HALT
  } state_e;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// Instruction handshake plus register-file read/write bus; master is the
// sequencer, slave is the fetch logic / register file side.
interface reg_access_ctrl_if
  import reg_ctrl_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [AW-1:0]      rdreg;
  logic [DW-1:0]      rdt;
  logic [AW-1:0]      wtreg;
  logic [DW-1:0]      wtdt;
  logic               rgw;

  modport master (
    input  instr, instr_valid, rdt,
    output instr_ready, rdreg, wtreg, wtdt, rgw
  );

  modport slave (
    output instr, instr_valid, rdt,
    input  instr_ready, rdreg, wtreg, wtdt, rgw
  );
endinterface

// File: rtl/reg_ctrl_alu.sv
// Combinational accumulator ALU; result and carry/borrow taken from a DW+1 bit sum.
module reg_ctrl_alu
  import reg_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [2:0]    op_i,
  input  logic [DW-1:0] acc_i,
  input  logic [DW-1:0] rdt_i,
  output logic [DW-1:0] result_o,
  output logic          carry_o
);
  logic [DW:0] wide;

  always_comb begin
    wide = {1'b0, rdt_i};
    case (op_i)
      OP_ADD:  wide = {1'b0, acc_i} + {1'b0, rdt_i};
      // Top bit of the widened difference is the borrow (acc < rdt).
      OP_SUB:  wide = {1'b0, acc_i} - {1'b0, rdt_i};
      OP_AND:  wide = {1'b0, acc_i & rdt_i};
      OP_OR:   wide = {1'b0, acc_i | rdt_i};
      default: wide = {1'b0, rdt_i};
    endcase
  end

  assign result_o = wide[DW-1:0];
  assign carry_o  = wide[DW];
endmodule

// File: rtl/reg_access_ctrl.sv
// Multi-cycle accumulator sequencer in front of the register file.
// Optional Z/C flag outputs under `define REG_ACCESS_CTRL_FLAGS_EN.
module reg_access_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int            DW      = 8,
  parameter int            AW      = 3,
  parameter logic [DW-1:0] ACC_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  reg_access_ctrl_if.master bus,
  output logic [DW-1:0]     acc,
  output logic              busy,
  output logic              halted
`ifdef REG_ACCESS_CTRL_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_c
`endif
);
  state_e             state_q;
  logic [INSTR_W-1:0] instr_q;
  logic [DW-1:0]      acc_q;
  logic [AW-1:0]      rdreg_q;
  logic [AW-1:0]      wtreg_q;
  logic [DW-1:0]      wtdt_q;
  logic               rgw_q;
  logic [2:0]         op;
  logic [AW-1:0]      r_idx;
  logic [DW-1:0]      alu_res;
  logic               alu_carry;
  logic               unused_bits;

  assign op    = instr_q[OP_MSB:OP_LSB];
  assign r_idx = instr_q[R_LSB +: AW];

  reg_ctrl_alu #(.DW(DW)) u_alu (
    .op_i    (op),
    .acc_i   (acc_q),
    .rdt_i   (bus.rdt),
    .result_o(alu_res),
    .carry_o (alu_carry)
  );

`ifdef REG_ACCESS_CTRL_FLAGS_EN
  logic flag_z_q;
  logic flag_c_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      acc_q   <= ACC_RST;
      rdreg_q <= '0;
      wtreg_q <= '0;
      wtdt_q  <= '0;
      rgw_q   <= 1'b0;
`ifdef REG_ACCESS_CTRL_FLAGS_EN
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
`endif
    end else begin
      rgw_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (op)
            OP_NOP:  state_q <= ST_IDLE;
            OP_HALT: state_q <= ST_HALT;
            OP_STA: begin
              wtreg_q <= r_idx;
              wtdt_q  <= acc_q;
              state_q <= ST_WR_SETUP;
            end
            default: begin
              rdreg_q <= r_idx;
              state_q <= ST_READ;
            end
          endcase
        end
        ST_READ: state_q <= ST_EXEC;
        ST_EXEC: begin
          acc_q   <= alu_res;
`ifdef REG_ACCESS_CTRL_FLAGS_EN
          flag_z_q <= (alu_res == '0);
          flag_c_q <= alu_carry;
`endif
          state_q <= ST_IDLE;
        end
        ST_WR_SETUP: begin
          rgw_q   <= 1'b1;
          state_q <= ST_WR_PULSE;
        end
        ST_WR_PULSE: state_q <= ST_WR_HOLD;
        ST_WR_HOLD:  state_q <= ST_IDLE;
        ST_HALT:     state_q <= ST_HALT;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  // Reserved instruction bits carry no meaning; carry is only consumed with flags enabled.
  assign unused_bits = ^{instr_q[R_LSB-1:0], alu_carry};

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.rdreg       = rdreg_q;
  assign bus.wtreg       = wtreg_q;
  assign bus.wtdt        = wtdt_q;
  assign bus.rgw         = rgw_q;
  assign acc             = acc_q;
  assign busy            = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted          = (state_q == ST_HALT);
endmodule

// File: tb/tb_reg_access_ctrl.sv
// Self-checking bench for reg_access_ctrl: directed table, backpressure,
// randomized instructions against a behavioural model, reset-in-write and HALT.
module tb_reg_access_ctrl;
  import reg_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] acc;
  logic       busy;
  logic       halted;
`ifdef REG_ACCESS_CTRL_FLAGS_EN
  logic       flag_z;
  logic       flag_c;
`endif

  int errs   = 0;
  int checks = 0;
  int acc_cnt = 0;

  reg_access_ctrl_if #(.DW(8), .AW(3)) bus ();

  reg_access_ctrl #(.DW(8), .AW(3), .ACC_RST(8'h00)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .acc   (acc),
    .busy  (busy),
    .halted(halted)
`ifdef REG_ACCESS_CTRL_FLAGS_EN
    ,
    .flag_z(flag_z),
    .flag_c(flag_c)
`endif
  );

  always #5 clk = ~clk;

  // Register file environment
  logic [7:0] regs [8] = '{8'h01, 8'h01, 8'hC0, 8'h01, 8'h01, 8'h01, 8'h10, 8'h01};
  assign bus.rdt = regs[bus.rdreg];
  always @(posedge clk) if (bus.rgw) regs[bus.wtreg] <= bus.wtdt;

  always @(posedge clk) if (!rst && bus.instr_valid && bus.instr_ready) acc_cnt <= acc_cnt + 1;

  // Behavioural model state
  int mregs [8] = '{1, 1, 192, 1, 1, 1, 16, 1};
  int macc = 0;
  logic mc = 1'b0;
  logic mz = 1'b0;

  typedef struct {
    logic [7:0] ins;
    int         lat;
    int         acc;
    logic       c;
    logic       z;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_exec(input logic [7:0] ins, output int lat);
    int a, b, s;
    logic [2:0] op, r;
    op = ins[7:5];
    r  = ins[4:2];
    a  = macc;
    b  = mregs[r];
    lat = 4;
    case (op)
      OP_NOP: lat = 2;
      OP_STA: begin mregs[r] = macc; lat = 5; end
      OP_LDA: begin macc = b; mc = 1'b0; end
      OP_ADD: begin s = a + b; macc = s % 256; mc = (s > 255); end
      OP_SUB: begin mc = (a < b); macc = (a - b + 256) % 256; end
      OP_AND: begin macc = a & b; mc = 1'b0; end
      OP_OR:  begin macc = a | b; mc = 1'b0; end
      default: lat = 0;
    endcase
    if (lat == 4) mz = (macc == 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("pre_ready", 32'(bus.instr_ready), 32'd1);
  endtask

  task automatic issue(input logic [7:0] ins, input int exp_lat, input int exp_acc,
                       input logic exp_c, input logic exp_z);
    int n, rgw_n;
    logic ok_rd, ok_wr, ok_busy, is_rd;
    logic [2:0] op, r;
    op = ins[7:5];
    r  = ins[4:2];
    is_rd = (op != OP_NOP) && (op != OP_STA) && (op != OP_HALT);
    rgw_n = 0; ok_rd = 1'b1; ok_wr = 1'b1; ok_busy = 1'b1;
    wait_ready();
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    n = 1;
    while (!bus.instr_ready && n < 20) begin
      rgw_n += int'(bus.rgw);
      if (!busy) ok_busy = 1'b0;
      if (is_rd && (n == 2 || n == 3) && bus.rdreg != r) ok_rd = 1'b0;
      if (op == OP_STA && n >= 2 && n <= 4 && (bus.wtreg != r || bus.wtdt != exp_acc[7:0])) ok_wr = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("rgw_pulses", 32'(rgw_n), (op == OP_STA) ? 32'd1 : 32'd0);
    chk("rdreg_hold", 32'(ok_rd), 32'd1);
    chk("wr_stable", 32'(ok_wr), 32'd1);
    chk("busy", 32'(ok_busy), 32'd1);
    chk("acc", 32'(acc), 32'(exp_acc));
`ifdef REG_ACCESS_CTRL_FLAGS_EN
    chk("flag_c", 32'(flag_c), 32'(exp_c));
    chk("flag_z", 32'(flag_z), 32'(exp_z));
`endif
  endtask

  initial begin
    int lat, n, n0;
    logic [2:0] op, r;
    logic [7:0] ins;

    tbl[0]  = '{8'h28, 4, 'hC0, 1'b0, 1'b0};  // LDA R2
    tbl[1]  = '{8'h68, 4, 'h80, 1'b1, 1'b0};  // ADD R2
    tbl[2]  = '{8'h98, 4, 'h70, 1'b0, 1'b0};  // SUB R6
    tbl[3]  = '{8'h54, 5, 'h70, 1'b0, 1'b0};  // STA R5
    tbl[4]  = '{8'h34, 4, 'h70, 1'b0, 1'b0};  // LDA R5
    tbl[5]  = '{8'hA0, 4, 'h00, 1'b0, 1'b1};  // AND R0
    tbl[6]  = '{8'hD8, 4, 'h10, 1'b0, 1'b0};  // OR R6
    tbl[7]  = '{8'h80, 4, 'h0F, 1'b0, 1'b0};  // SUB R0
    tbl[8]  = '{8'h98, 4, 'hFF, 1'b1, 1'b0};  // SUB R6 borrow
    tbl[9]  = '{8'h00, 2, 'hFF, 1'b1, 1'b0};  // NOP
    tbl[10] = '{8'h6C, 4, 'h00, 1'b1, 1'b1};  // ADD R3 wraps to zero
    tbl[11] = '{8'h03, 2, 'h00, 1'b1, 1'b1};  // NOP, reserved bits set

    rst = 1'b1;
    bus.instr = 8'h00;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_acc", 32'(acc), 32'h0);
    chk("rst_rgw", 32'(bus.rgw), 32'h0);
    chk("rst_ready", 32'(bus.instr_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
`ifdef REG_ACCESS_CTRL_FLAGS_EN
    chk("rst_flag_c", 32'(flag_c), 32'h0);
    chk("rst_flag_z", 32'(flag_z), 32'h0);
`endif

    for (int i = 0; i < 12; i++) begin
      model_exec(tbl[i].ins, lat);
      issue(tbl[i].ins, tbl[i].lat, tbl[i].acc, tbl[i].c, tbl[i].z);
    end
    chk("sta_r5", 32'(regs[5]), 32'h70);

    // Valid held high across a whole LDA while the instruction changes underneath.
    wait_ready();
    n0 = acc_cnt;
    bus.instr = 8'h24;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr = 8'h64;
    n = 0;
    while (!bus.instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_lat", 32'(n), 32'd3);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    n = 0;
    while (!bus.instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    model_exec(8'h24, lat);
    model_exec(8'h64, lat);
    chk("bp_accepts", 32'(acc_cnt - n0), 32'd2);
    chk("bp_acc", 32'(acc), 32'(macc));

    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 6));
      r   = 3'($urandom_range(0, 7));
      ins = {op, r, 2'($urandom_range(0, 3))};
      model_exec(ins, lat);
      issue(ins, lat, macc, mc, mz);
    end
    for (int i = 0; i < 8; i++) chk("regfile", 32'(regs[i]), 32'(mregs[i]));

    // Reset landing on the write pulse.
    wait_ready();
    bus.instr = 8'h4C;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wp_rgw_high", 32'(bus.rgw), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mregs[3] = macc;
    macc = 0;
    chk("wp_rgw_low", 32'(bus.rgw), 32'h0);
    chk("wp_ready", 32'(bus.instr_ready), 32'h1);
    chk("wp_busy", 32'(busy), 32'h0);
    chk("wp_acc", 32'(acc), 32'(macc));
    chk("wp_r3", 32'(regs[3]), 32'(mregs[3]));

    // HALT is sticky until reset.
    bus.instr = 8'hE0;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_busy", 32'(busy), 32'h0);
    chk("halt_ready", 32'(bus.instr_ready), 32'h0);
    n0 = acc_cnt;
    bus.instr = 8'h28;
    bus.instr_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    chk("halt_accepts", 32'(acc_cnt - n0), 32'd0);
    chk("halt_sticky", 32'(halted), 32'h1);
    chk("halt_acc", 32'(acc), 32'(macc));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("halt_exit", 32'(halted), 32'h0);
    chk("halt_exit_ready", 32'(bus.instr_ready), 32'h1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
